// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding, default
// qualification length and small state-decode helpers.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    function automatic logic is_high_level(input state_e s);
        return (s == STABLE_HI) || (s == WAIT_LO);
    endfunction

    function automatic logic is_qualifying(input state_e s);
        return (s == WAIT_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Capture stage followed by a settling stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/input_debouncer.sv
// Counter-qualified debouncer for a raw button/switch input.
// Define DEBOUNCE_EDGE_EN to generate rise_pulse/fall_pulse; otherwise both are tied low.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_async,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s_in;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dout_q, dout_d;
    logic                 busy_q, busy_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din_async),
        .q     (s_in)
    );

    // State, qualification counter and level outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= CNT_ZERO;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: the first differing sample counts as 1, the last one accepts the level.
    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        case (state_q)
            STABLE_LO: begin
                if (s_in) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = STABLE_LO;
                end
            end
            WAIT_HI: begin
                if (!s_in) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s_in) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = STABLE_HI;
                end
            end
            WAIT_LO: begin
                if (s_in) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Level outputs decoded from the state being entered, then registered.
    always_comb begin
        dout_d = is_high_level(state_d);
        busy_d = is_qualifying(state_d);
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_d, fall_d;
    logic rise_q, fall_q;

    // A pulse marks only a completed qualification, never a rejected glitch.
    always_comb begin
        rise_d = (state_q == WAIT_HI) && (state_d == STABLE_HI);
        fall_d = (state_q == WAIT_LO) && (state_d == STABLE_LO);
    end

    // Edge pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4); pulse expectations
// follow whether DEBOUNCE_EDGE_EN is defined for the build.
module tb_input_debouncer;

    localparam int N = 4;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif
    localparam logic [3:0] PULSE_MASK = {1'b1, EDGE_EN, EDGE_EN, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_async = 1'b0;
    logic dout, rise_pulse, fall_pulse, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw samples delayed two edges, level flips after N differing samples.
    bit dhist[$];
    bit shist[$];
    bit m_dout, m_rise, m_fall, m_busy;

    typedef struct {
        bit         din;
        logic [3:0] exp;   // {dout, rise_pulse, fall_pulse, busy}
    } vec_t;
    vec_t vecs[$];

    input_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_async  (din_async),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {dout, rise_pulse, fall_pulse, busy};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {dout,rise,fall,busy}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        dhist = '{1'b0, 1'b0};
        shist.delete();
        for (int i = 0; i < N; i++) shist.push_back(1'b0);
        m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_edge(input bit d);
        bit fsm_in;
        bit all_diff;
        fsm_in = dhist.pop_front();
        dhist.push_back(d);
        shist.push_back(fsm_in);
        void'(shist.pop_front());
        all_diff = 1'b1;
        foreach (shist[i]) if (shist[i] == m_dout) all_diff = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (all_diff) begin
            m_dout = ~m_dout;
            if (m_dout) m_rise = 1'b1;
            else        m_fall = 1'b1;
        end
        m_busy = !all_diff && (fsm_in != m_dout);
    endtask

    // One clock with din driven beforehand; outputs sampled 1 time unit after the edge.
    task automatic step(input bit d, input string tag);
        din_async = d;
        @(posedge clk);
        model_edge(d);
        #1;
        check(tag, outs(), {m_dout, m_rise, m_fall, m_busy} & PULSE_MASK);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_immediate", outs(), 4'b0000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", outs(), 4'b0000);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_hi;
        int rises;
        int falls;
        bit lvl;
        int run;

        // Rising qualification, falling qualification, then a 3-cycle glitch.
        vecs.push_back('{1'b1, 4'b0000}); vecs.push_back('{1'b1, 4'b0000});
        vecs.push_back('{1'b1, 4'b0001}); vecs.push_back('{1'b1, 4'b0001});
        vecs.push_back('{1'b1, 4'b0001}); vecs.push_back('{1'b1, 4'b1100});
        vecs.push_back('{1'b1, 4'b1000}); vecs.push_back('{1'b0, 4'b1000});
        vecs.push_back('{1'b0, 4'b1000}); vecs.push_back('{1'b0, 4'b1001});
        vecs.push_back('{1'b0, 4'b1001}); vecs.push_back('{1'b0, 4'b1001});
        vecs.push_back('{1'b0, 4'b0010}); vecs.push_back('{1'b0, 4'b0000});
        vecs.push_back('{1'b1, 4'b0000}); vecs.push_back('{1'b1, 4'b0000});
        vecs.push_back('{1'b1, 4'b0001}); vecs.push_back('{1'b0, 4'b0001});
        vecs.push_back('{1'b0, 4'b0001}); vecs.push_back('{1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b0000});

        model_reset();
        #2;
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].din, "table_model");
            check($sformatf("table_row%0d", i + 1), outs(), vecs[i].exp & PULSE_MASK);
        end

        // Bouncing input: only the final 4-sample run may qualify.
        do_reset();
        first_hi = 0; rises = 0; falls = 0;
        for (int i = 1; i <= 15; i++) begin
            bit pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            step((i <= 9) ? pat[i-1] : 1'b1, "bounce_model");
            if (dout && first_hi == 0) first_hi = i;
            rises += int'(rise_pulse);
            falls += int'(fall_pulse);
        end
        check_int("bounce_first_high_edge", first_hi, 11);
        check_int("bounce_rise_count", rises, int'(EDGE_EN));
        check_int("bounce_fall_count", falls, 0);

        // Reset during WAIT_HI with two samples counted; a fresh full qualification must follow.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, "wait_hi_prefix");
        check("wait_hi_busy_before_reset", outs(), 4'b0001);
        do_reset();
        first_hi = 0; rises = 0;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, "after_reset_model");
            if (dout && first_hi == 0) first_hi = i;
            rises += int'(rise_pulse);
        end
        check_int("after_reset_first_high_edge", first_hi, 1 + 1 + N);
        check_int("after_reset_rise_count", rises, int'(EDGE_EN));

        // Random runs of 1..7 cycles, including one reset in the middle.
        lvl = 1'b0;
        for (int r = 0; r < 80; r++) begin
            lvl = ~lvl;
            run = $urandom_range(7, 1);
            for (int k = 0; k < run; k++) step(lvl, "random_model");
            if (r == 40) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
